decoder_3_8_strobe: RTL

//  - Registered 3:8 decoder with valid/ready input and timed one-hot strobe output.
//  - Accepts a 3-bit code and drives out = 8'b1 << code for HOLD_CYCLES cycles, then idles GAP_CYCLES.
//  - Return path for the 8:3 priority encoder: regenerates one-hot select/strobe lines from a code.

---
 rtl/dec_pkg.sv | 14 +
 rtl/decoder_3_8.sv | 11 +
 rtl/decoder_3_8_strobe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types and widths for the 3:8 strobe decoder
package dec_pkg;

  localparam int IN_W  = 3;
  localparam int OUT_W = 8;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_3_8.sv
// rtl/decoder_3_8.sv - combinational binary code to one-hot decode
module decoder_3_8
  import dec_pkg::*;
(
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  assign out = OUT_W'(1) << in;

endmodule

// File: rtl/decoder_3_8_strobe.sv
// rtl/decoder_3_8_strobe.sv - registered 3:8 decoder driving timed one-hot strobes
// Optional one-entry skid register enabled by defining DEC_3_8_SKID_EN.
module decoder_3_8_strobe
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [OUT_W-1:0] out_nxt;
  logic [OUT_W-1:0] dec_code;
  logic [IN_W-1:0]  load_code;
  logic             load;
  logic             finishing;
  logic             xfer;

  assign xfer      = in_valid && in_ready;
  assign out_valid = |out;

  decoder_3_8 u_dec (
    .in  (load_code),
    .out (dec_code)
  );

`ifdef DEC_3_8_SKID_EN
  logic            skid_full, skid_full_nxt;
  logic [IN_W-1:0] skid_code, skid_code_nxt;

  assign in_ready = !skid_full;
  assign busy     = (state != IDLE) || skid_full;
`else
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    load      = 1'b0;
    load_code = in;
    finishing = 1'b0;
`ifdef DEC_3_8_SKID_EN
    skid_full_nxt = skid_full;
    skid_code_nxt = skid_code;
`endif

    case (state)
      IDLE: begin
        if (xfer) load = 1'b1;
      end
      DRIVE: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LOAD;
            out_nxt   = '0;
          end else begin
            finishing = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) finishing = 1'b1;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    if (finishing) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      out_nxt   = '0;
    end

`ifdef DEC_3_8_SKID_EN
    // A pending code replaces the IDLE cycle so strobes run back to back.
    if (finishing) begin
      if (skid_full) begin
        load          = 1'b1;
        load_code     = skid_code;
        skid_full_nxt = 1'b0;
      end else if (xfer) begin
        load = 1'b1;
      end
    end else if ((state != IDLE) && xfer) begin
      skid_full_nxt = 1'b1;
      skid_code_nxt = in;
    end
`endif

    if (load) begin
      state_nxt = DRIVE;
      cnt_nxt   = HOLD_LOAD;
      out_nxt   = dec_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
    end
  end

`ifdef DEC_3_8_SKID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_code <= '0;
    end else begin
      skid_full <= skid_full_nxt;
      skid_code <= skid_code_nxt;
    end
  end
`endif

endmodule
